// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the writeback arbiter and its clients.
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: NUM_REQ valid/ready channels carrying a destination register and data.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][REG_AW-1:0] req_reg;
  logic [NUM_REQ-1:0][XLEN-1:0]   req_data;
  logic [NUM_REQ-1:0]             req_ready;

  modport master (
    output req_valid, req_reg, req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_reg, req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the requester just after last_grant has top priority.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       enable,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (enable && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-port arbiter for the register file with a registered output stage.
// Optional WB_ARB_PERF_EN adds per-requester saturating stall counters (stall_cnt).
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5
) (
  input  logic                    clock,
  input  logic                    reset_n,
  regfile_wb_arbiter_if.slave     req_if,
  input  logic                    wb_hold,
  output logic                    regwrite,
  output logic [REG_AW-1:0]       write_reg,
  output logic [XLEN-1:0]         write_data
`ifdef WB_ARB_PERF_EN
  , output logic [NUM_REQ-1:0][15:0] stall_cnt
`endif
);

  import regfile_pkg::*;

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   last_grant;
  logic [PTR_W-1:0]   gnt_idx_p0;
  logic [NUM_REQ-1:0] grant_p0;
  logic               vld_p0;
  logic               vld_p1;
  logic [REG_AW-1:0]  reg_p1;
  logic [XLEN-1:0]    data_p1;

  // Gating by reset_n keeps req_ready low for the whole reset window.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_if.req_valid),
    .enable     (!wb_hold && reset_n),
    .last_grant (last_grant),
    .grant      (grant_p0)
  );

  assign req_if.req_ready = grant_p0;
  assign vld_p0           = |grant_p0;

  always_comb begin
    gnt_idx_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_p0[i]) gnt_idx_p0 = PTR_W'(i);
  end

  // ---- stage p0 -> p1: pointer update and output capture ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= PTR_W'(NUM_REQ - 1);
      vld_p1     <= 1'b0;
      reg_p1     <= '0;
      data_p1    <= '0;
    end else if (vld_p0) begin
      last_grant <= gnt_idx_p0;
      reg_p1     <= req_if.req_reg[gnt_idx_p0];
      data_p1    <= req_if.req_data[gnt_idx_p0];
      vld_p1     <= (req_if.req_reg[gnt_idx_p0] != REG_AW'(REG_ZERO));
    end else begin
      vld_p1     <= 1'b0;
    end
  end

  assign regwrite   = vld_p1;
  assign write_reg  = reg_p1;
  assign write_data = data_p1;

`ifdef WB_ARB_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++)
        if (req_if.req_valid[k] && !grant_p0[k])
          stall_cnt[k] <= sat_inc(stall_cnt[k]);
    end
  end
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the 32×32 register file. Several writeback sources share the file's single write port: ALU, load unit and multiply/divide. Each source presents a valid/ready request carrying a destination register and data. The block grants one request per cycle in round-robin order and drives the register file's `regwrite`, `write_reg` and `write_data` from a registered output stage.

## Interface
- `NUM_REQ`, 3: number of writeback requesters, 2..8.
- `XLEN`, 32: data width.
- `REG_AW`, 5: register address width.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester write request.
- `req_reg`  in  NUM_REQ×REG_AW  per-requester destination register.
- `req_data`  in  NUM_REQ×XLEN  per-requester write data.
- `req_ready`  out  NUM_REQ  grant; a transfer occurs when `valid & ready` at a rising edge.
- `wb_hold`  in  1  pipeline freeze; no grants while high.
- `regwrite`  out  1  to register file.
- `write_reg`  out  REG_AW  to register file.
- `write_data`  out  XLEN  to register file.

## Operation
- Round-robin pointer `last_grant`, range 0..NUM_REQ-1.
  - Priority order each cycle: `last_grant+1`, `last_grant+2`, … mod NUM_REQ.
- `req_ready` is combinational.
  - At most one bit is set.
  - The set bit is the highest-priority requester with `req_valid=1`, provided `wb_hold=0`.
  - All zero if no requester is valid or `wb_hold=1`.
- `req_ready` never depends on `req_reg` or `req_data`.
- On a transfer from requester k:
  - `last_grant <= k`.
  - The output stage captures `req_reg[k]` and `req_data[k]`.
  - `regwrite <= (req_reg[k] != 0)`.
- A write to x0 is consumed: ready asserted, pointer advances. The register file is not written and `regwrite` stays 0.
- With no transfer, `regwrite <= 0`. `write_reg` and `write_data` hold their last values.
- Requester contract: `req_reg` and `req_data` stay stable while valid and not ready. A valid request is never withdrawn before grant.
  - The arbiter does not check this contract.
- Two requesters targeting the same register in one cycle: the grant order decides. The later grant overwrites; no merging.
- Starvation bound: a continuously valid requester is granted within NUM_REQ cycles in which `wb_hold=0`.

## Timing
- Latency: the grant edge is edge T. `regwrite`, `write_reg` and `write_data` are valid T→T+1, and the register file commits at edge T+1.
  - The register file's internal forwarding covers same-cycle reads.
- Throughput: one write per cycle.
- `wb_hold` rising:
  - No grant in that cycle.
  - A write already in the output stage still completes; `regwrite` is high for its one cycle.
- Reset (async assert, synchronous deassert at the block level):
  - `regwrite=0`, `write_reg=0`, `write_data=0`.
  - `last_grant=NUM_REQ-1`, so requester 0 has first priority.
  - `req_ready=0` while `reset_n=0`.
- Reset mid-transfer: a pending output write is discarded. `regwrite` drops immediately on assert.

## Configuration
- `WB_ARB_PERF_EN` defined: adds output `stall_cnt`, NUM_REQ×16 bits.
  - The counter for requester k increments each cycle it is valid and not ready.
  - Counters saturate at 0xFFFF and clear on reset.
- `WB_ARB_PERF_EN` undefined: the port and counters are absent. Arbitration is unchanged.

## Structure
- Shared package `regfile_pkg` holds:
  - `XLEN` and `REG_AW` constants.
  - `REG_ZERO` constant (5'd0).
  - `wb_req_t` typedef (valid, reg, data).
- Sub-module `rr_arbiter`:
  - Parameter NUM_REQ.
  - Inputs: `req`, `enable`, `last_grant`.
  - Output: one-hot `grant`.
  - Purely combinational.
- The pointer and output stage live in the top module.

## Test plan
- Reset, then requester 1 only, `req_reg=5`, `req_data=0xDEADBEEF` → `req_ready=3'b010` the same cycle; `regwrite=1`, `write_reg=5`, `write_data=0xDEADBEEF` the next cycle only.
- All 3 requesters valid for 6 cycles → grant sequence 0,1,2,0,1,2, with `regwrite` high 6 consecutive cycles.
- Requester 0 writes x0 with data 0x1234 → `req_ready[0]=1`, `regwrite` stays 0, and the next grant goes to requester 1 when requesters 1 and 0 are both valid.
- `wb_hold=1` for 3 cycles with all requesters valid → `req_ready=0` throughout. After release the grant resumes at `last_grant+1`; with `WB_ARB_PERF_EN`, each `stall_cnt` equals 3 plus wait cycles.
- Requesters 0 and 2 both target reg 7, with data 0xA and 0xB → two consecutive writes, in pointer order. The register file ends holding the later-granted value.
- `reset_n` pulled low while a grant sits in the output stage → `regwrite` drops asynchronously and the write never reaches the register file.
